// File: rtl/live_cell_encoder.sv
// Purpose: serialises a row bitmap of live cells into binary column indices, lowest index first.
// Latency: first index one cycle after the bitmap is accepted, then one index per accepted transfer.
// Backpressure: index outputs hold while IDX_READY is low; LOAD_READY is low for the whole scan.
module live_cell_encoder #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD_VALID,
  input  logic [WIDTH-1:0] LOAD_DATA,
  output logic             LOAD_READY,
  output logic             IDX_VALID,
  input  logic             IDX_READY,
  output logic [IDX_W-1:0] IDX_OUT,
  output logic             IDX_LAST,
  output logic [CNT_W-1:0] LIVE_COUNT,
  output logic             EMPTY_PULSE
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Index of the lowest set bit; 0 for an empty mask (never used in that case).
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [WIDTH-1:0] m);
    lowest_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

  // Number of set bits in the bitmap.
  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] m);
    popcount = '0;
    for (int i = 0; i < WIDTH; i++) begin
      popcount = popcount + CNT_W'(m[i]);
    end
  endfunction

  // True when exactly one bit is set, i.e. the lowest set bit is also the last.
  function automatic logic single_bit(input logic [WIDTH-1:0] m);
    single_bit = (m != '0) && ((m & (m - WIDTH'(1))) == '0);
  endfunction

  state_t             state, state_nx;
  logic [WIDTH-1:0]   mask, mask_nx;
  logic               idx_vld, idx_vld_nx;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic               idx_last, idx_last_nx;
  logic [CNT_W-1:0]   live_cnt, live_cnt_nx;
  logic               empty_pls, empty_pls_nx;
  logic [WIDTH-1:0]   mask_clr;
  logic               load_acc;
  logic               idx_acc;

  // Mask holds the bits still to be emitted, including the one currently on IDX_OUT.
  assign mask_clr = mask & ~(WIDTH'(1) << idx);
  assign load_acc = (state == IDLE) && LOAD_VALID;
  assign idx_acc  = (state == SCAN) && idx_vld && IDX_READY;

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_nx     = state;
    mask_nx      = mask;
    idx_vld_nx   = idx_vld;
    idx_nx       = idx;
    idx_last_nx  = idx_last;
    live_cnt_nx  = live_cnt;
    empty_pls_nx = 1'b0;
    case (state)
      IDLE: begin
        if (load_acc) begin
          mask_nx     = LOAD_DATA;
          live_cnt_nx = popcount(LOAD_DATA);
          if (LOAD_DATA == '0) begin
            empty_pls_nx = 1'b1;
          end else begin
            state_nx    = SCAN;
            idx_vld_nx  = 1'b1;
            idx_nx      = lowest_idx(LOAD_DATA);
            idx_last_nx = single_bit(LOAD_DATA);
          end
        end
      end
      SCAN: begin
        if (idx_acc) begin
          mask_nx = mask_clr;
          if (idx_last) begin
            // Return to IDLE; the next load is taken no earlier than the following cycle.
            state_nx    = IDLE;
            idx_vld_nx  = 1'b0;
            idx_nx      = '0;
            idx_last_nx = 1'b0;
          end else begin
            idx_nx      = lowest_idx(mask_clr);
            idx_last_nx = single_bit(mask_clr);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers with synchronous reset that discards any scan in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      mask      <= '0;
      idx_vld   <= 1'b0;
      idx       <= '0;
      idx_last  <= 1'b0;
      live_cnt  <= '0;
      empty_pls <= 1'b0;
    end else begin
      state     <= state_nx;
      mask      <= mask_nx;
      idx_vld   <= idx_vld_nx;
      idx       <= idx_nx;
      idx_last  <= idx_last_nx;
      live_cnt  <= live_cnt_nx;
      empty_pls <= empty_pls_nx;
    end
  end

  assign LOAD_READY  = (state == IDLE);
  assign IDX_VALID   = idx_vld;
  assign IDX_OUT     = idx;
  assign IDX_LAST    = idx_last;
  assign LIVE_COUNT  = live_cnt;
  assign EMPTY_PULSE = empty_pls;

endmodule

// File: tb/tb_live_cell_encoder.sv
// Purpose: self-checking bench for live_cell_encoder with directed scenarios and a random scoreboard.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: random IDX_READY stalls exercised against a bitmap-level reference model.
module tb_live_cell_encoder;

  localparam int WIDTH = 8;
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             CLK = 1'b0;
  logic             RST;
  logic             LOAD_VALID;
  logic [WIDTH-1:0] LOAD_DATA;
  logic             LOAD_READY;
  logic             IDX_VALID;
  logic             IDX_READY;
  logic [IDX_W-1:0] IDX_OUT;
  logic             IDX_LAST;
  logic [CNT_W-1:0] LIVE_COUNT;
  logic             EMPTY_PULSE;

  int checks = 0;
  int errors = 0;

  live_cell_encoder #(.WIDTH(WIDTH)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .LOAD_VALID (LOAD_VALID),
    .LOAD_DATA  (LOAD_DATA),
    .LOAD_READY (LOAD_READY),
    .IDX_VALID  (IDX_VALID),
    .IDX_READY  (IDX_READY),
    .IDX_OUT    (IDX_OUT),
    .IDX_LAST   (IDX_LAST),
    .LIVE_COUNT (LIVE_COUNT),
    .EMPTY_PULSE(EMPTY_PULSE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; LOAD_VALID = 1'b0; LOAD_DATA = '0; IDX_READY = 1'b0;
    tick(); tick();
    RST = 1'b0;
    checks++; if (LOAD_READY !== 1'b1) begin errors++; $display("FAIL reset_load_ready got %b want 1", LOAD_READY); end
    checks++; if (IDX_VALID !== 1'b0) begin errors++; $display("FAIL reset_idx_valid got %b want 0", IDX_VALID); end
    checks++; if (IDX_OUT !== '0) begin errors++; $display("FAIL reset_idx_out got %0d want 0", IDX_OUT); end
    checks++; if (IDX_LAST !== 1'b0) begin errors++; $display("FAIL reset_idx_last got %b want 0", IDX_LAST); end
    checks++; if (LIVE_COUNT !== '0) begin errors++; $display("FAIL reset_live_count got %0d want 0", LIVE_COUNT); end
    checks++; if (EMPTY_PULSE !== 1'b0) begin errors++; $display("FAIL reset_empty got %b want 0", EMPTY_PULSE); end
  endtask

  task automatic test_basic();
    LOAD_VALID = 1'b1; LOAD_DATA = 8'b0010_0100; IDX_READY = 1'b1;
    tick();
    LOAD_VALID = 1'b0;
    checks++; if (LOAD_READY !== 1'b0) begin errors++; $display("FAIL basic_load_ready got %b want 0", LOAD_READY); end
    checks++; if ({IDX_VALID, IDX_OUT, IDX_LAST} !== {1'b1, 3'd2, 1'b0}) begin errors++; $display("FAIL basic_first got v=%b idx=%0d last=%b want v=1 idx=2 last=0", IDX_VALID, IDX_OUT, IDX_LAST); end
    checks++; if (LIVE_COUNT !== 4'd2) begin errors++; $display("FAIL basic_count got %0d want 2", LIVE_COUNT); end
    tick();
    checks++; if ({IDX_VALID, IDX_OUT, IDX_LAST} !== {1'b1, 3'd5, 1'b1}) begin errors++; $display("FAIL basic_second got v=%b idx=%0d last=%b want v=1 idx=5 last=1", IDX_VALID, IDX_OUT, IDX_LAST); end
    tick();
    checks++; if ({IDX_VALID, IDX_OUT, LOAD_READY} !== {1'b0, 3'd0, 1'b1}) begin errors++; $display("FAIL basic_done got v=%b idx=%0d rdy=%b want v=0 idx=0 rdy=1", IDX_VALID, IDX_OUT, LOAD_READY); end
    checks++; if (LIVE_COUNT !== 4'd2) begin errors++; $display("FAIL basic_count_hold got %0d want 2", LIVE_COUNT); end
  endtask

  task automatic test_empty();
    LOAD_VALID = 1'b1; LOAD_DATA = 8'h00;
    tick();
    LOAD_VALID = 1'b0;
    checks++; if (EMPTY_PULSE !== 1'b1) begin errors++; $display("FAIL empty_pulse got %b want 1", EMPTY_PULSE); end
    checks++; if ({IDX_VALID, LOAD_READY} !== 2'b01) begin errors++; $display("FAIL empty_flags got v=%b rdy=%b want v=0 rdy=1", IDX_VALID, LOAD_READY); end
    checks++; if (LIVE_COUNT !== '0) begin errors++; $display("FAIL empty_count got %0d want 0", LIVE_COUNT); end
    tick();
    checks++; if ({EMPTY_PULSE, IDX_VALID} !== 2'b00) begin errors++; $display("FAIL empty_after got pulse=%b v=%b want 0 0", EMPTY_PULSE, IDX_VALID); end
  endtask

  task automatic test_all_ones();
    LOAD_VALID = 1'b1; LOAD_DATA = 8'hFF; IDX_READY = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      tick();
      LOAD_VALID = 1'b0;
      checks++;
      if ({IDX_VALID, IDX_OUT, IDX_LAST} !== {1'b1, IDX_W'(i), (i == WIDTH - 1)}) begin
        errors++; $display("FAIL ones_step%0d got v=%b idx=%0d last=%b", i, IDX_VALID, IDX_OUT, IDX_LAST);
      end
    end
    tick();
    checks++; if ({IDX_VALID, LOAD_READY} !== 2'b01) begin errors++; $display("FAIL ones_done got v=%b rdy=%b want v=0 rdy=1", IDX_VALID, LOAD_READY); end
    checks++; if (LIVE_COUNT !== 4'd8) begin errors++; $display("FAIL ones_count got %0d want 8", LIVE_COUNT); end
  endtask

  task automatic test_backpressure();
    LOAD_VALID = 1'b1; LOAD_DATA = 8'b1000_0001; IDX_READY = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      // A second load attempt during the scan must be ignored.
      LOAD_VALID = 1'b1; LOAD_DATA = 8'h0F;
      checks++;
      if ({IDX_VALID, IDX_OUT, IDX_LAST, LOAD_READY} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
        errors++; $display("FAIL bp_hold%0d got v=%b idx=%0d last=%b rdy=%b want v=1 idx=0 last=0 rdy=0", c, IDX_VALID, IDX_OUT, IDX_LAST, LOAD_READY);
      end
    end
    IDX_READY = 1'b1;
    tick();
    LOAD_VALID = 1'b0;
    checks++; if ({IDX_VALID, IDX_OUT, IDX_LAST} !== {1'b1, 3'd7, 1'b1}) begin errors++; $display("FAIL bp_release got v=%b idx=%0d last=%b want v=1 idx=7 last=1", IDX_VALID, IDX_OUT, IDX_LAST); end
    checks++; if (LIVE_COUNT !== 4'd2) begin errors++; $display("FAIL bp_count got %0d want 2", LIVE_COUNT); end
    tick();
    checks++; if ({IDX_VALID, LOAD_READY} !== 2'b01) begin errors++; $display("FAIL bp_done got v=%b rdy=%b want v=0 rdy=1", IDX_VALID, LOAD_READY); end
  endtask

  task automatic test_reset_mid_scan();
    LOAD_VALID = 1'b1; LOAD_DATA = 8'b0101_0101; IDX_READY = 1'b1;
    tick();
    LOAD_VALID = 1'b0;
    tick();
    checks++; if (IDX_OUT !== 3'd2) begin errors++; $display("FAIL mid_idx2 got %0d want 2", IDX_OUT); end
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++; if ({IDX_VALID, IDX_OUT, IDX_LAST, LOAD_READY} !== {1'b0, 3'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL mid_reset got v=%b idx=%0d last=%b rdy=%b want v=0 idx=0 last=0 rdy=1", IDX_VALID, IDX_OUT, IDX_LAST, LOAD_READY); end
    checks++; if (LIVE_COUNT !== '0) begin errors++; $display("FAIL mid_reset_count got %0d want 0", LIVE_COUNT); end
    LOAD_VALID = 1'b1; LOAD_DATA = 8'h80;
    tick();
    LOAD_VALID = 1'b0;
    checks++; if ({IDX_VALID, IDX_OUT, IDX_LAST} !== {1'b1, 3'd7, 1'b1}) begin errors++; $display("FAIL mid_reload got v=%b idx=%0d last=%b want v=1 idx=7 last=1", IDX_VALID, IDX_OUT, IDX_LAST); end
    checks++; if (LIVE_COUNT !== 4'd1) begin errors++; $display("FAIL mid_reload_count got %0d want 1", LIVE_COUNT); end
    tick();
    checks++; if (IDX_VALID !== 1'b0) begin errors++; $display("FAIL mid_reload_done got v=%b want 0", IDX_VALID); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] bm;
    int               exp_q[$];
    int               got_q[$];
    int               exp_cnt;
    bit               done;
    bit               hold;
    bit               rdy;
    logic [IDX_W-1:0] prev_idx;
    logic             prev_last;
    int               wait_cyc;
    for (int n = 0; n < 60; n++) begin
      bm = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
      exp_q.delete();
      got_q.delete();
      exp_cnt = 0;
      for (int b = 0; b < WIDTH; b++) begin
        if (bm[b]) begin exp_q.push_back(b); exp_cnt++; end
      end
      wait_cyc = 0;
      while (LOAD_READY !== 1'b1 && wait_cyc < 20) begin tick(); wait_cyc++; end
      checks++; if (LOAD_READY !== 1'b1) begin errors++; $display("FAIL rnd%0d_ready_timeout got %b want 1", n, LOAD_READY); end
      IDX_READY = 1'b0;
      LOAD_VALID = 1'b1; LOAD_DATA = bm;
      tick();
      LOAD_VALID = 1'b0;
      checks++; if (LIVE_COUNT !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", n, LIVE_COUNT, exp_cnt); end
      checks++; if (EMPTY_PULSE !== (exp_cnt == 0)) begin errors++; $display("FAIL rnd%0d_empty got %b want %b", n, EMPTY_PULSE, exp_cnt == 0); end
      if (exp_cnt == 0) begin
        checks++; if (IDX_VALID !== 1'b0) begin errors++; $display("FAIL rnd%0d_empty_valid got %b want 0", n, IDX_VALID); end
        continue;
      end
      done = 1'b0; hold = 1'b0; prev_idx = '0; prev_last = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        if (hold) begin
          checks++;
          if ({IDX_OUT, IDX_LAST} !== {prev_idx, prev_last}) begin
            errors++; $display("FAIL rnd%0d_stall got idx=%0d last=%b want idx=%0d last=%b", n, IDX_OUT, IDX_LAST, prev_idx, prev_last);
          end
        end
        checks++;
        if (IDX_VALID !== 1'b1) begin
          errors++; $display("FAIL rnd%0d_valid_drop got %b want 1", n, IDX_VALID);
          break;
        end
        rdy = ($urandom_range(0, 3) != 0);
        IDX_READY = rdy;
        if (rdy) begin
          got_q.push_back(int'(IDX_OUT));
          if (IDX_LAST) done = 1'b1;
        end
        hold = !rdy; prev_idx = IDX_OUT; prev_last = IDX_LAST;
        tick();
      end
      IDX_READY = 1'b0;
      checks++; if (!done) begin errors++; $display("FAIL rnd%0d_no_last got 0 last want 1", n); end
      checks++; if (got_q != exp_q) begin errors++; $display("FAIL rnd%0d_indices got %p want %p (bitmap %b)", n, got_q, exp_q, bm); end
      checks++; if ({IDX_VALID, LOAD_READY} !== 2'b01) begin errors++; $display("FAIL rnd%0d_done got v=%b rdy=%b want v=0 rdy=1", n, IDX_VALID, LOAD_READY); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_all_ones();
    test_backpressure();
    test_reset_mid_scan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
